// File: rtl/icache_line.sv
// icache_line: direct-mapped instruction cache with multi-word lines.
//
// A miss starts a burst refill of the whole line, one word per accepted memory
// beat. Each returning word is forwarded to the fetcher if it is the word the
// fetcher wants. Array hits keep being served while the refill is in flight.
// A flush clears every valid bit in one cycle.
//
// Ports:
//   clk_in, rst_in       clock, asynchronous active-high reset
//   rdy_in               global ready; when low all state is frozen
//   flush                invalidate all lines
//   fetch_able,input_pc  fetch request and its word-aligned address
//   hit,hit_ins,ins_pc   hit flag, instruction word, echo of input_pc
//   need_mem,mem_addr    refill request and address of the requested word
//   mem_ins,mem_ins_ready word returned by memory and its valid strobe
module icache_line #(
  parameter int unsigned INDEX_BITS       = 6,
  parameter int unsigned OFFSET_WORDS_LOG = 2,
  parameter int unsigned ADDR_WIDTH       = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        fetch_able,
  input  logic [31:0] input_pc,
  output logic        hit,
  output logic [31:0] hit_ins,
  output logic [31:0] ins_pc,
  output logic        need_mem,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_ins,
  input  logic        mem_ins_ready
);

  localparam int unsigned NumLines = 1 << INDEX_BITS;
  localparam int unsigned Words    = 1 << OFFSET_WORDS_LOG;
  localparam int unsigned IdxLsb   = OFFSET_WORDS_LOG + 2;
  localparam int unsigned TagLsb   = IdxLsb + INDEX_BITS;
  localparam int unsigned TagW     = ADDR_WIDTH - TagLsb;

  localparam logic [OFFSET_WORDS_LOG-1:0] LastWord = '1;

  typedef enum logic [0:0] {StIdle, StRefill} state_e;

  // Control state
  state_e                      state_q;
  logic                        need_mem_q;
  logic [31:0]                 mem_addr_q;
  logic [OFFSET_WORDS_LOG-1:0] cnt_q;
  logic                        discard_q;
  logic [NumLines-1:0]         valid_q;

  // Storage, deliberately not reset
  logic [TagW-1:0]             tag_q  [NumLines];
  logic [31:0]                 data_q [NumLines][Words];
  logic [31:0]                 line_q [Words];

  logic [INDEX_BITS-1:0]       pc_idx;
  logic [OFFSET_WORDS_LOG-1:0] pc_off;
  logic [TagW-1:0]             pc_tag;
  logic [INDEX_BITS-1:0]       ref_idx;
  logic [TagW-1:0]             ref_tag;
  logic                        arr_hit;
  logic                        fwd_hit;
  logic                        word_acc;
  logic                        commit;
  logic                        start;
  logic                        unused_pc;

  // Word address bits [1:0] never matter for a word-aligned fetch.
  assign unused_pc = ^input_pc[1:0];

  always_comb begin
    pc_idx  = input_pc[TagLsb-1:IdxLsb];
    pc_off  = input_pc[IdxLsb-1:2];
    pc_tag  = input_pc[ADDR_WIDTH-1:TagLsb];
    // mem_addr_q holds the refill line's index/tag for the whole burst.
    ref_idx = mem_addr_q[TagLsb-1:IdxLsb];
    ref_tag = mem_addr_q[ADDR_WIDTH-1:TagLsb];

    arr_hit  = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    // mem_ins_ready is meaningless while frozen, so no forwarding either.
    fwd_hit  = (state_q == StRefill) && rdy_in && mem_ins_ready && (mem_addr_q == input_pc);
    hit      = fetch_able && (arr_hit || fwd_hit);
    hit_ins  = fwd_hit ? mem_ins : data_q[pc_idx][pc_off];

    word_acc = (state_q == StRefill) && rdy_in && mem_ins_ready;
    commit   = word_acc && (cnt_q == LastWord);
    start    = (state_q == StIdle) && rdy_in && fetch_able && !hit && !flush;
  end

  assign ins_pc   = input_pc;
  assign need_mem = need_mem_q;
  assign mem_addr = mem_addr_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      need_mem_q <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
      valid_q    <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        valid_q <= '0;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRefill;
            need_mem_q <= 1'b1;
            mem_addr_q <= {input_pc[31:IdxLsb], {IdxLsb{1'b0}}};
            cnt_q      <= '0;
          end
        end
        StRefill: begin
          // A flush while the burst is running must not let this line come back valid.
          if (flush) begin
            discard_q <= 1'b1;
          end
          if (word_acc) begin
            cnt_q      <= cnt_q + OFFSET_WORDS_LOG'(1);
            mem_addr_q <= mem_addr_q + 32'd4;
            if (cnt_q == LastWord) begin
              // Later assignments override the flush clear/discard set above.
              valid_q[ref_idx] <= ~discard_q & ~flush;
              state_q          <= StIdle;
              need_mem_q       <= 1'b0;
              mem_addr_q       <= '0;
              discard_q        <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // commit/word_acc are both qualified by state_q, which reset forces to idle.
  always_ff @(posedge clk_in) begin
    if (word_acc) begin
      line_q[cnt_q] <= mem_ins;
    end
    if (commit) begin
      tag_q[ref_idx] <= ref_tag;
      for (int unsigned w = 0; w < Words; w++) begin
        // The last word is still on mem_ins, not yet in the line buffer.
        data_q[ref_idx][OFFSET_WORDS_LOG'(w)] <=
            (w == Words - 1) ? mem_ins : line_q[OFFSET_WORDS_LOG'(w)];
      end
    end
  end

endmodule

// File: tb/tb_icache_line.sv
module tb_icache_line;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        fetch_able;
  logic [31:0] input_pc;
  logic        hit;
  logic [31:0] hit_ins;
  logic [31:0] ins_pc;
  logic        need_mem;
  logic [31:0] mem_addr;
  logic [31:0] mem_ins;
  logic        mem_ins_ready;

  int checks = 0;
  int errors = 0;

  icache_line #(
    .INDEX_BITS      (6),
    .OFFSET_WORDS_LOG(2),
    .ADDR_WIDTH      (18)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush        (flush),
    .fetch_able   (fetch_able),
    .input_pc     (input_pc),
    .hit          (hit),
    .hit_ins      (hit_ins),
    .ins_pc       (ins_pc),
    .need_mem     (need_mem),
    .mem_addr     (mem_addr),
    .mem_ins      (mem_ins),
    .mem_ins_ready(mem_ins_ready)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", name, obs, exp);
      $error("check %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Combinational lookup only; no clock edge passes while fetch_able is high.
  task automatic probe(input logic [31:0] pc, input logic exp_hit, input logic [31:0] exp_ins);
    fetch_able = 1'b1;
    input_pc   = pc;
    #1;
    check("probe_hit", {31'd0, hit}, {31'd0, exp_hit});
    check("probe_ins_pc", ins_pc, pc);
    if (exp_hit) check("probe_ins", hit_ins, exp_ins);
    fetch_able = 1'b0;
  endtask

  task automatic start_miss(input logic [31:0] pc);
    fetch_able = 1'b1;
    input_pc   = pc;
    #1;
    check("miss_hit", {31'd0, hit}, 32'd0);
    @(posedge clk_in); #1;
    check("miss_need_mem", {31'd0, need_mem}, 32'd1);
    check("miss_mem_addr", mem_addr, {pc[31:4], 4'h0});
  endtask

  // One idle cycle, then one cycle with the word valid.
  task automatic mem_word(input logic [31:0] data, input logic [31:0] addr, input logic fl,
                          input logic fwd);
    mem_ins_ready = 1'b0;
    #1;
    check("word_need_mem", {31'd0, need_mem}, 32'd1);
    check("word_mem_addr", mem_addr, addr);
    if (fwd) check("fwd_gap_hit", {31'd0, hit}, 32'd0);
    @(posedge clk_in); #1;
    mem_ins       = data;
    mem_ins_ready = 1'b1;
    flush         = fl;
    #1;
    if (fwd) begin
      check("fwd_hit", {31'd0, hit}, {31'd0, addr == input_pc});
      if (addr == input_pc) check("fwd_ins", hit_ins, data);
    end
    @(posedge clk_in); #1;
    mem_ins_ready = 1'b0;
    flush         = 1'b0;
  endtask

  // d = {w3, w2, w1, w0}
  task automatic refill(input logic [31:0] pc, input logic [127:0] d, input int flush_at,
                        input logic fwd);
    logic [31:0] base;
    base = {pc[31:4], 4'h0};
    start_miss(pc);
    fetch_able = fwd;
    for (int i = 0; i < 4; i++) begin
      mem_word(d[32*i +: 32], base + 32'(4 * i), i == flush_at, fwd);
    end
    fetch_able = 1'b0;
    check("done_need_mem", {31'd0, need_mem}, 32'd0);
    check("done_mem_addr", mem_addr, 32'd0);
  endtask

  initial begin
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    flush         = 1'b0;
    fetch_able    = 1'b0;
    input_pc      = 32'd0;
    mem_ins       = 32'd0;
    mem_ins_ready = 1'b0;
    #12 rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Reset state
    check("rst_need_mem", {31'd0, need_mem}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    probe(32'h100, 1'b0, 32'd0);

    // 1: cold miss with forwarding of the first word
    refill(32'h100, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 1'b1);
    probe(32'h100, 1'b1, 32'h11);
    probe(32'h104, 1'b1, 32'h22);
    probe(32'h108, 1'b1, 32'h33);
    probe(32'h10C, 1'b1, 32'h44);
    check("hit_no_need_mem", {31'd0, need_mem}, 32'd0);

    // 2: critical-word forward after a fresh reset
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
    probe(32'h108, 1'b0, 32'd0);
    refill(32'h108, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 1'b1);
    probe(32'h108, 1'b1, 32'h33);

    // 3: conflict at the same index, different tag; high PC bits are ignored
    probe(32'hFFFC_0104, 1'b1, 32'h22);
    refill(32'h500, {32'h54, 32'h53, 32'h52, 32'h51}, -1, 1'b0);
    probe(32'h500, 1'b1, 32'h51);
    probe(32'h50C, 1'b1, 32'h54);
    probe(32'h100, 1'b0, 32'd0);

    // 4: flush mid-refill, flush on the last word, flush on an idle miss
    refill(32'h200, {32'h64, 32'h63, 32'h62, 32'h61}, -1, 1'b0);
    probe(32'h204, 1'b1, 32'h62);
    refill(32'h300, {32'h74, 32'h73, 32'h72, 32'h71}, 2, 1'b0);
    probe(32'h300, 1'b0, 32'd0);
    probe(32'h500, 1'b0, 32'd0);
    probe(32'h200, 1'b0, 32'd0);
    refill(32'h600, {32'h94, 32'h93, 32'h92, 32'h91}, 3, 1'b0);
    probe(32'h600, 1'b0, 32'd0);
    fetch_able = 1'b1;
    input_pc   = 32'h700;
    flush      = 1'b1;
    @(posedge clk_in); #1;
    fetch_able = 1'b0;
    flush      = 1'b0;
    check("flush_idle_no_refill", {31'd0, need_mem}, 32'd0);

    // 5: hit-under-refill, rdy_in stall, async reset mid-refill
    refill(32'h100, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 1'b0);
    start_miss(32'h400);
    fetch_able = 1'b0;
    mem_word(32'hA1, 32'h400, 1'b0, 1'b0);
    probe(32'h104, 1'b1, 32'h22);
    mem_ins       = 32'hA2;
    mem_ins_ready = 1'b1;
    rdy_in        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      check("stall_mem_addr", mem_addr, 32'h404);
      check("stall_need_mem", {31'd0, need_mem}, 32'd1);
    end
    rdy_in        = 1'b1;
    mem_ins_ready = 1'b0;
    mem_word(32'hA2, 32'h404, 1'b0, 1'b0);
    mem_word(32'hA3, 32'h408, 1'b0, 1'b0);
    mem_word(32'hA4, 32'h40C, 1'b0, 1'b0);
    check("stall_done_need_mem", {31'd0, need_mem}, 32'd0);
    probe(32'h400, 1'b1, 32'hA1);
    probe(32'h404, 1'b1, 32'hA2);
    probe(32'h40C, 1'b1, 32'hA4);

    start_miss(32'h800);
    fetch_able = 1'b0;
    mem_word(32'hB1, 32'h800, 1'b0, 1'b0);
    probe(32'h408, 1'b1, 32'hA3);
    rst_in = 1'b1;
    #1;
    check("async_rst_need_mem", {31'd0, need_mem}, 32'd0);
    check("async_rst_mem_addr", mem_addr, 32'd0);
    probe(32'h100, 1'b0, 32'd0);
    probe(32'h400, 1'b0, 32'd0);
    rst_in        = 1'b0;
    mem_ins_ready = 1'b1;
    @(posedge clk_in); #1;
    mem_ins_ready = 1'b0;
    check("post_rst_need_mem", {31'd0, need_mem}, 32'd0);
    probe(32'h800, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
